// File: rtl/pipe_perf_counter_if.sv
// pipe_perf_counter_if
// Bundles the control strobes, event inputs and readback signals of
// pipe_perf_counter. The monitor takes the slave modport. Whatever drives
// the controls and reads the results (a bench or debug port) takes master.
//   start_i   level enable for counting
//   clear_i   synchronous clear of counters, flags and state
//   freeze_i  level pause request while running
//   snap_i    copy live counters into the shadow registers
//   event_i   per-channel event strobes
//   rd_sel_i  shadow select (NUM_CH selects the cycle counter)
//   rd_data_o selected shadow value
//   ovf_o     sticky overflow flags (bit NUM_CH = cycle counter)
//   state_o   00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done_o    high while in DONE
interface pipe_perf_counter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic              start_i;
  logic              clear_i;
  logic              freeze_i;
  logic              snap_i;
  logic [NUM_CH-1:0] event_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic [CNT_W-1:0]  rd_data_o;
  logic [NUM_CH:0]   ovf_o;
  logic [1:0]        state_o;
  logic              done_o;

  modport master (
    output start_i, clear_i, freeze_i, snap_i, event_i, rd_sel_i,
    input  rd_data_o, ovf_o, state_o, done_o
  );

  modport slave (
    input  start_i, clear_i, freeze_i, snap_i, event_i, rd_sel_i,
    output rd_data_o, ovf_o, state_o, done_o
  );
endinterface

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter
// Performance monitor for the pipelined CPU. It counts RUN cycles and up to
// NUM_CH single-bit pipeline events. Optionally it stops after CYCLE_LIMIT
// counted cycles. Live counters can be snapshotted into shadow registers,
// and those shadows are read back combinationally.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  asynchronous active-high reset
//   bus    pipe_perf_counter_if slave modport (controls, events, readback)
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | not counting, counts held; waits for start_i
// RUN    | cycle counter and event channels count every cycle
// PAUSE  | freeze_i held while running; events are dropped
// DONE   | cycle limit reached; held until clear_i or reset
module pipe_perf_counter #(
  parameter int              NUM_CH      = 4,
  parameter int              CNT_W       = 32,
  parameter int              SAT_MODE    = 0,
  parameter longint unsigned CYCLE_LIMIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_perf_counter_if.slave   bus
);

  localparam int               NCNT     = NUM_CH + 1;
  localparam bit               LIMIT_EN = (CYCLE_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_T  = CNT_W'(CYCLE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [CNT_W-1:0] shd_q [NCNT];
  logic [NCNT-1:0]  ovf_q;
  logic [NCNT-1:0]  ovf_d;
  logic [NCNT-1:0]  inc_en;
  logic             limit_hit;
  logic [CNT_W-1:0] rd_data;

  // The top bit is the cycle counter, which counts every RUN cycle.
  always_comb begin
    inc_en = '0;
    if (state_q == S_RUN) inc_en = {1'b1, bus.event_i};
  end

  // Increment with overflow handling. An increment at all-ones sets the
  // sticky flag, then either wraps to zero or saturates.
  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (inc_en[k]) begin
        if (cnt_q[k] == {CNT_W{1'b1}}) begin
          ovf_d[k] = 1'b1;
          cnt_d[k] = (SAT_MODE != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // The limit is checked against the incremented value. The last counted
  // cycle therefore still records its events, and the move to DONE
  // happens on that same edge.
  assign limit_hit = LIMIT_EN && (cnt_d[NUM_CH] == LIMIT_T);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      ovf_q   <= '0;
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k] <= '0;
        shd_q[k] <= '0;
      end
    end else begin
      // The snapshot takes the pre-edge values, so it wins over a clear
      // on the same edge.
      if (bus.snap_i) begin
        for (int k = 0; k < NCNT; k++) shd_q[k] <= cnt_q[k];
      end

      if (bus.clear_i) begin
        state_q <= S_IDLE;
        done_q  <= 1'b0;
        ovf_q   <= '0;
        for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      end else begin
        for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
        ovf_q <= ovf_d;
        unique case (state_q)
          S_IDLE: begin
            if (bus.start_i) state_q <= S_RUN;
          end
          S_RUN: begin
            if (!bus.start_i) begin
              state_q <= S_IDLE;
            end else if (limit_hit) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (bus.freeze_i) begin
              state_q <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!bus.start_i)      state_q <= S_IDLE;
            else if (!bus.freeze_i) state_q <= S_RUN;
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(bus.rd_sel_i) <= NUM_CH) rd_data = shd_q[bus.rd_sel_i];
  end

  assign bus.rd_data_o = rd_data;
  assign bus.ovf_o     = ovf_q;
  assign bus.state_o   = state_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_pipe_perf_counter.sv
module tb_pipe_perf_counter;
  localparam int NUM_CH = 4;
  localparam int NI     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, clear = 1'b0, freeze = 1'b0, snap = 1'b0;
  logic [3:0] ev = '0;
  logic [2:0] rd_sel = '0;
  bit         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_perf_counter_if #(.NUM_CH(NUM_CH), .CNT_W(32)) if0 ();
  pipe_perf_counter_if #(.NUM_CH(NUM_CH), .CNT_W(8))  if1 ();
  pipe_perf_counter_if #(.NUM_CH(NUM_CH), .CNT_W(8))  if2 ();

  assign if0.start_i = start;  assign if1.start_i = start;  assign if2.start_i = start;
  assign if0.clear_i = clear;  assign if1.clear_i = clear;  assign if2.clear_i = clear;
  assign if0.freeze_i = freeze; assign if1.freeze_i = freeze; assign if2.freeze_i = freeze;
  assign if0.snap_i = snap;    assign if1.snap_i = snap;    assign if2.snap_i = snap;
  assign if0.event_i = ev;     assign if1.event_i = ev;     assign if2.event_i = ev;
  assign if0.rd_sel_i = rd_sel; assign if1.rd_sel_i = rd_sel; assign if2.rd_sel_i = rd_sel;

  pipe_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(32), .SAT_MODE(0), .CYCLE_LIMIT(64))
    u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  pipe_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(8), .SAT_MODE(0), .CYCLE_LIMIT(0))
    u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  pipe_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(8), .SAT_MODE(1), .CYCLE_LIMIT(0))
    u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  logic [63:0] rd_o   [NI];
  logic [4:0]  ovf_o  [NI];
  logic [1:0]  st_o   [NI];
  logic        done_o [NI];

  assign rd_o[0] = 64'(if0.rd_data_o); assign rd_o[1] = 64'(if1.rd_data_o); assign rd_o[2] = 64'(if2.rd_data_o);
  assign ovf_o[0] = if0.ovf_o; assign ovf_o[1] = if1.ovf_o; assign ovf_o[2] = if2.ovf_o;
  assign st_o[0] = if0.state_o; assign st_o[1] = if1.state_o; assign st_o[2] = if2.state_o;
  assign done_o[0] = if0.done_o; assign done_o[1] = if1.done_o; assign done_o[2] = if2.done_o;

  // Reference model: counters kept as plain 64-bit integers and reduced to
  // each instance's width. Index 4 is the cycle counter.
  int              W   [NI] = '{32, 8, 8};
  int              SAT [NI] = '{0, 0, 1};
  longint unsigned LIM [NI] = '{64, 0, 0};

  longint unsigned m_cnt [NI][5];
  longint unsigned m_shd [NI][5];
  bit              m_ovf [NI][5];
  int              m_st  [NI];   // 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE

  function automatic longint unsigned maxv(int i);
    return (64'd1 << W[i]) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0;
      for (int k = 0; k < 5; k++) begin
        m_cnt[i][k] = 0; m_shd[i][k] = 0; m_ovf[i][k] = 1'b0;
      end
    end
  endtask

  task automatic bump(int i, int k);
    if (m_cnt[i][k] == maxv(i)) begin
      m_ovf[i][k] = 1'b1;
      m_cnt[i][k] = (SAT[i] != 0) ? maxv(i) : 64'd0;
    end else begin
      m_cnt[i][k] = m_cnt[i][k] + 1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (snap) for (int k = 0; k < 5; k++) m_shd[i][k] = m_cnt[i][k];
      if (clear) begin
        m_st[i] = 0;
        for (int k = 0; k < 5; k++) begin m_cnt[i][k] = 0; m_ovf[i][k] = 1'b0; end
      end else begin
        case (m_st[i])
          0: if (start) m_st[i] = 1;
          1: begin
            bump(i, 4);
            for (int k = 0; k < NUM_CH; k++) if (ev[k]) bump(i, k);
            if (!start) m_st[i] = 0;
            else if (LIM[i] != 0 && m_cnt[i][4] == (LIM[i] & maxv(i))) m_st[i] = 3;
            else if (freeze) m_st[i] = 2;
          end
          2: if (!start) m_st[i] = 0; else if (!freeze) m_st[i] = 1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(string name, longint unsigned got, longint unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic [4:0]      e_ovf;
        longint unsigned e_rd;
        for (int k = 0; k < 5; k++) e_ovf[k] = m_ovf[i][k];
        e_rd = (rd_sel <= 3'd4) ? m_shd[i][rd_sel] : 64'd0;
        chk($sformatf("u%0d rd_data sel=%0d", i, rd_sel), rd_o[i], e_rd);
        chk($sformatf("u%0d ovf_o", i), 64'(ovf_o[i]), 64'(e_ovf));
        chk($sformatf("u%0d state_o", i), 64'(st_o[i]), 64'(m_st[i]));
        chk($sformatf("u%0d done_o", i), 64'(done_o[i]), (m_st[i] == 3) ? 64'd1 : 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic lit(string name, int inst, logic [2:0] sel, longint unsigned exp);
    rd_sel = sel;
    #1;
    chk(name, rd_o[inst], exp);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    lit("reset rd cyc", 0, 3'd4, 0);
    chk("reset state", 64'(st_o[0]), 0);
    chk("reset ovf", 64'(ovf_o[0]), 0);

    // Run to the limit with ch0 always high; 8-bit instances wrap/saturate
    start = 1'b1; ev = 4'b0001; tick();
    repeat (260) tick();
    start = 1'b0; ev = 4'b0000; tick();
    tick();
    snap = 1'b1; tick(); snap = 1'b0;
    repeat (10) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    lit("limit cyc", 0, 3'd4, 64);
    lit("limit ch0", 0, 3'd0, 64);
    chk("limit done", 64'(done_o[0]), 1);
    chk("limit state", 64'(st_o[0]), 3);
    chk("limit ovf", 64'(ovf_o[0]), 0);
    lit("wrap ch0", 1, 3'd0, 4);
    lit("wrap cyc", 1, 3'd4, 5);
    chk("wrap ovf", 64'(ovf_o[1]), 64'h11);
    lit("sat ch0", 2, 3'd0, 255);
    lit("sat cyc", 2, 3'd4, 255);
    chk("sat ovf", 64'(ovf_o[2]), 64'h11);
    lit("oob sel5", 0, 3'd5, 0);
    lit("oob sel7", 1, 3'd7, 0);

    // snap and clear together
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick();
    ev = 4'b0100; repeat (17) tick();
    ev = 4'b0000; start = 1'b0; tick();
    snap = 1'b1; clear = 1'b1; tick(); snap = 1'b0; clear = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lit($sformatf("snapclr u%0d ch2", i), i, 3'd2, 17);
      chk($sformatf("snapclr u%0d ovf", i), 64'(ovf_o[i]), 0);
      chk($sformatf("snapclr u%0d state", i), 64'(st_o[i]), 0);
    end
    snap = 1'b1; tick(); snap = 1'b0;
    lit("post-clear live ch2", 0, 3'd2, 0);

    // Freeze window drops events
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick();
    for (int c = 0; c < 40; c++) begin
      ev = (c % 3 == 0) ? 4'b0010 : 4'b0000;
      freeze = (c >= 10 && c < 20);
      tick();
    end
    ev = 4'b0000; freeze = 1'b0; start = 1'b0; tick();
    snap = 1'b1; tick(); snap = 1'b0;
    lit("freeze cyc", 0, 3'd4, 31);
    lit("freeze ch1", 0, 3'd1, 11);
    lit("freeze cyc u2", 2, 3'd4, 31);

    // Restart resumes from held counts
    start = 1'b1; tick();
    ev = 4'b0001; repeat (5) tick();
    ev = 4'b0000; start = 1'b0; tick();
    snap = 1'b1; tick(); snap = 1'b0;
    lit("resume cyc", 0, 3'd4, 37);
    lit("resume ch0", 0, 3'd0, 5);
    lit("resume ch1", 1, 3'd1, 11);
    chk("resume state", 64'(st_o[0]), 0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      start  = ($urandom_range(0, 15) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      snap   = ($urandom_range(0, 3) == 0);
      clear  = ($urandom_range(0, 63) == 0);
      ev     = 4'($urandom);
      rd_sel = 3'($urandom);
      tick();
    end

    // Asynchronous reset mid-run
    clear = 1'b1; freeze = 1'b0; snap = 1'b0; tick(); clear = 1'b0;
    start = 1'b1; ev = 4'hF; repeat (10) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    lit("pre-reset cyc", 0, 3'd4, 9);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("async rst u%0d rd", i), rd_o[i], 0);
      chk($sformatf("async rst u%0d state", i), 64'(st_o[i]), 0);
      chk($sformatf("async rst u%0d ovf", i), 64'(ovf_o[i]), 0);
      chk($sformatf("async rst u%0d done", i), 64'(done_o[i]), 0);
    end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    start = 1'b0; ev = 4'h0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_perf_counter.md
# pipe_perf_counter

Parametrised in-RTL performance monitor for the pipelined CPU. It counts clock cycles and up to NUM_CH single-bit pipeline events, such as stall, flush, branch-taken and retire. A stop-after-N-cycles limit, snapshot shadow registers and per-channel overflow flags replace the cycle, stall and flush bookkeeping previously done only in simulation. It sits beside CPU, with event inputs wired from hazard detection and control, and is readable by a bench or debug port.

## Interface
- NUM_CH, 4, number of event channels (1..16)
- CNT_W, 32, width of every counter (8..64)
- SAT_MODE, 0, 0 = counters wrap to 0 on overflow; 1 = counters saturate at all-ones
- CYCLE_LIMIT, 64, RUN ends after this many counted cycles; 0 = unlimited
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  level enable; 1 permits counting, 0 returns to IDLE
- clear_i  in  1  synchronous clear of counters, flags and state
- freeze_i  in  1  level pause request while running
- snap_i  in  1  one-cycle pulse; copy live counters to shadow registers
- event_i  in  NUM_CH  per-channel event strobes, sampled each cycle
- rd_sel_i  in  $clog2(NUM_CH+1)  shadow select: 0..NUM_CH-1 = channel, NUM_CH = cycle counter
- rd_data_o  out  CNT_W  shadow value selected by rd_sel_i (combinational)
- ovf_o  out  NUM_CH+1  sticky overflow flags; bit NUM_CH = cycle counter
- state_o  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- done_o  out  1  high while in DONE

## Operation
- State transitions, evaluated each edge in priority order:
  - rst_i
  - clear_i → IDLE
  - IDLE: start_i=1 → RUN
  - RUN: start_i=0 → IDLE; limit reached → DONE; freeze_i=1 → PAUSE
  - PAUSE: start_i=0 → IDLE; freeze_i=0 → RUN
  - DONE: held until clear_i or rst_i; start_i is ignored
- Counting happens only in RUN. The cycle counter increments every RUN cycle. Channel k increments when event_i[k]=1.
  - IDLE, PAUSE and DONE hold all counts.
- Limit: when CYCLE_LIMIT≠0 and the cycle counter increments to CYCLE_LIMIT, the next state is DONE.
  - Events in that final RUN cycle are still counted.
  - The limit beats freeze_i in the same cycle.
- Overflow: an increment at all-ones sets the sticky ovf bit.
  - SAT_MODE=0: the value becomes 0.
  - SAT_MODE=1: the value stays all-ones.
  - The cycle counter obeys the same rule. If it wraps to 0 before reaching CYCLE_LIMIT, the limit is not hit again until it counts back up.
- clear_i zeroes the live counters and ovf_o and sets state IDLE. Shadow registers are not cleared.
- snap_i copies all NUM_CH+1 live counters into the shadows, using the values held before this edge's update.
  - snap_i with clear_i in the same cycle: the shadows get the pre-clear values.
- rd_data_o: rd_sel_i > NUM_CH returns 0.
- All counter arithmetic is unsigned at CNT_W. The limit comparison uses CNT_W bits; a CYCLE_LIMIT wider than CNT_W is truncated.

## Timing
- Reset values: all counters, shadows and ovf_o = 0; state_o = 00; done_o = 0; rd_data_o = 0.
- rst_i asserted mid-run takes effect immediately (asynchronous), with no partial update.
- Count latency is 1 cycle: an event sampled at edge N is visible in the live counter after edge N. It reaches rd_data_o only after a snap_i at edge ≥ N+1.
- snap_i at edge N makes the shadows visible on rd_data_o from edge N onward, combinationally through rd_sel_i.
- start_i rising at edge N: state is RUN after N. Counting begins with the events sampled at edge N+1.
- freeze_i is level-sensitive. Every cycle sampled in PAUSE loses its events; they are not buffered.
- done_o is asserted in the cycle after the CYCLE_LIMIT-th counted cycle and holds until clear or reset.

## Test plan
- Reset, start_i=1, event_i[0]=1 constantly, CYCLE_LIMIT=64, then snap → cycle shadow = 64, ch0 = 64, done_o=1, state_o=11; counts hold over 10 further cycles.
- event_i[1] pulsed every 3rd cycle, freeze_i high for cycles 10..19 → ch1 excludes pulses during PAUSE; cycle count = elapsed RUN cycles only.
- CNT_W=8, SAT_MODE=0, ch0 held high for 260 RUN cycles with CYCLE_LIMIT=0 → ch0 = 4, ovf_o[0]=1; SAT_MODE=1 → ch0 = 255, ovf_o[0]=1.
- snap_i and clear_i in the same cycle with ch2 = 17 → shadow ch2 = 17; live ch2 = 0; state IDLE; ovf_o = 0.
- rst_i pulsed asynchronously mid-RUN with counters nonzero → all outputs 0 and state IDLE immediately, before the next clk_i edge.
- rd_sel_i = NUM_CH+1 (out of range) → rd_data_o = 0; start_i dropped in RUN → IDLE with counts held; start_i reasserted → counting resumes from held values.
